// File: rtl/dram_wr_pkg.sv
// Shared widths, field positions and FSM encoding for the DRAM write controller.
package dram_wr_pkg;

  localparam int unsigned CMD_W    = 40;
  localparam int unsigned DATA_W   = 36;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WDATA_W  = 32;
  localparam int unsigned LEN_MSB  = 39;
  localparam int unsigned LEN_LSB  = 32;
  localparam int unsigned STRB_MSB = 35;
  localparam int unsigned STRB_LSB = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pushes while full are ignored (full checked pre-pop).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head word reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/dram_write_ctrl.sv
// Buffers write words and burst commands, replaying each command as one valid/ready DRAM
// write burst (address, data, response phases).
module dram_write_ctrl
  import dram_wr_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 256,
  parameter int unsigned CMD_DEPTH  = 16,
  parameter int unsigned MAX_LEN    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_we,
  input  logic [CMD_W-1:0]    ctrl_in,
  input  logic                ctrl_we,
  output logic                data_full,
  output logic                ctrl_full,
  output logic                overflow,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic [7:0]          mem_awlen,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [WDATA_W-1:0]  mem_wdata,
  output logic [3:0]          mem_wstrb,
  output logic                mem_wlast,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic                mem_bvalid,
  output logic                mem_bready
);

  localparam int unsigned DCW       = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned CCW       = $clog2(CMD_DEPTH) + 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  logic [DATA_W-1:0] data_head;
  logic              data_empty;
  logic [DCW-1:0]    data_count;
  logic              data_pop;
  logic [CMD_W-1:0]  cmd_head;
  logic              cmd_empty;
  logic [CCW-1:0]    cmd_count;
  logic              cmd_pop;

  logic [7:0]        head_len;
  logic [ADDR_W-1:0] head_addr;
  logic              bad_len;
  logic              last_beat;

  state_t            state, nxt_state;
  logic [7:0]        len_q, nxt_len;
  logic [7:0]        beat_cnt, nxt_beat;
  logic [ADDR_W-1:0] nxt_awaddr;
  logic [7:0]        nxt_awlen;
  logic              nxt_awvalid, nxt_wvalid, nxt_wlast, nxt_bready;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .din   (data_in),
    .push  (data_we),
    .pop   (data_pop),
    .dout  (data_head),
    .full  (data_full),
    .empty (data_empty),
    .count (data_count)
  );

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .din   (ctrl_in),
    .push  (ctrl_we),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (ctrl_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  assign head_len  = cmd_head[LEN_MSB:LEN_LSB];
  assign head_addr = cmd_head[ADDR_W-1:0];
  assign last_beat = (beat_cnt == len_q - 8'd1);
  assign mem_wdata = data_head[WDATA_W-1:0];
  assign mem_wstrb = data_head[STRB_MSB:STRB_LSB];
  assign busy      = (state != ST_IDLE) || !data_empty || (cmd_count != '0);

  // Next-state and next-output logic; bus outputs are held unless a transition changes them.
  always_comb begin
    nxt_state   = state;
    nxt_len     = len_q;
    nxt_beat    = beat_cnt;
    nxt_awaddr  = mem_awaddr;
    nxt_awlen   = mem_awlen;
    nxt_awvalid = mem_awvalid;
    nxt_wvalid  = mem_wvalid;
    nxt_wlast   = mem_wlast;
    nxt_bready  = mem_bready;
    cmd_pop     = 1'b0;
    data_pop    = 1'b0;
    bad_len     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cmd_empty) begin
          if (head_len == 8'd0 || head_len > MAX_LEN_B) begin
            cmd_pop = 1'b1;
            bad_len = 1'b1;
          end else if (data_count >= DCW'(head_len)) begin
            cmd_pop     = 1'b1;
            nxt_len     = head_len;
            nxt_awaddr  = head_addr;
            nxt_awlen   = head_len - 8'd1;
            nxt_awvalid = 1'b1;
            nxt_state   = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (mem_awready) begin
          nxt_awvalid = 1'b0;
          nxt_wvalid  = 1'b1;
          nxt_beat    = 8'd0;
          nxt_wlast   = (len_q == 8'd1);
          nxt_state   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem_wready) begin
          data_pop = 1'b1;
          if (last_beat) begin
            nxt_wvalid = 1'b0;
            nxt_wlast  = 1'b0;
            nxt_bready = 1'b1;
            nxt_state  = ST_RESP;
          end else begin
            nxt_beat  = beat_cnt + 8'd1;
            nxt_wlast = (beat_cnt + 8'd2 == len_q);
          end
        end
      end
      ST_RESP: begin
        if (mem_bvalid) begin
          nxt_bready = 1'b0;
          nxt_state  = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      mem_awaddr  <= '0;
      mem_awlen   <= '0;
      mem_awvalid <= 1'b0;
      mem_wvalid  <= 1'b0;
      mem_wlast   <= 1'b0;
      mem_bready  <= 1'b0;
    end else begin
      state       <= nxt_state;
      len_q       <= nxt_len;
      beat_cnt    <= nxt_beat;
      mem_awaddr  <= nxt_awaddr;
      mem_awlen   <= nxt_awlen;
      mem_awvalid <= nxt_awvalid;
      mem_wvalid  <= nxt_wvalid;
      mem_wlast   <= nxt_wlast;
      mem_bready  <= nxt_bready;
    end
  end

  // Sticky error: dropped push or illegal command length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if ((data_we && data_full) || (ctrl_we && ctrl_full) || bad_len) begin
      overflow <= 1'b1;
    end
  end

endmodule
